steak_timer: RTL and testbench
==============================

Name: steak_timer

Overview:
Timing source for the steak doneness controller. It generates the `show` request that spawns a steak after a randomised delay, and the `stage_clk` level that toggles once per doneness stage while cooking is enabled. It consumes the controller's `steak_show_resetn`, `steakShowTime` and `clockEn` outputs, closing the spawn/cook handshake loop.

Parameters:
TICK_DIV, 50000000, clk cycles per time unit (1 s at 50 MHz); must be >= 2
COOK_UNITS, 2, time units per doneness stage (stage_clk half-period); must be >= 1
SHOW_BASE, 1, time units added to show_time for the spawn delay; range 0..8

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
show_resetn  input  1  from controller steak_show_resetn; 0 = no steak present, 1 = steak on grill
show_time  input  3  from controller steakShowTime; random spawn delay in units
cook_en  input  1  from controller clockEn; 1 = cooking advances, 0 = paused (flip wait)
show  output  1  spawn request to controller
stage_clk  output  1  doneness stage level to controller `clock` input
stage_cnt  output  3  stage toggles since cook start, saturating at 7 (score/debug)

Behaviour:
- reset=1 at a posedge: next state S_IDLE; show=0, stage_clk=0, stage_cnt=0, prescaler=0, unit counter=0, delay register=0. Reset has priority over all other events, in any state, including mid-delay or mid-cook.
- Prescaler: counts 0..TICK_DIV-1. The terminal cycle (prescaler==TICK_DIV-1) is a unit tick. The prescaler clears on every state change.
- FSM states: S_IDLE, S_DELAY, S_SHOW, S_COOK. All outputs are registered.
- S_IDLE:
  - show=0, stage_clk=0.
  - If show_resetn==0: latch delay_units = show_time + SHOW_BASE (4-bit, max 15, no overflow), clear counters, go to S_DELAY.
  - Otherwise stay in S_IDLE.
- S_DELAY:
  - Prescaler runs every cycle, independent of cook_en.
  - On each unit tick, the unit counter increments.
  - On the tick where unit counter+1 == delay_units, go to S_SHOW; show=1 from the next cycle.
  - delay_units==0 (only possible with SHOW_BASE=0 and show_time=0): go to S_SHOW on the first cycle.
  - Total cycles spent in S_DELAY = delay_units*TICK_DIV.
  - If show_resetn==1 in S_DELAY: go directly to S_COOK with stage_clk=0 and show=0.
- S_SHOW:
  - show held at 1.
  - When show_resetn==1: go to S_COOK. show=0, stage_clk=0, stage_cnt=0, counters cleared.
- S_COOK:
  - The prescaler advances only when cook_en==1; it holds its value when cook_en==0 (pause is cycle-exact).
  - On each unit tick with cook_en==1, the unit counter increments.
  - When the unit counter reaches COOK_UNITS: the unit counter clears, stage_clk inverts, and stage_cnt increments, saturating at 7.
  - stage_clk keeps toggling after saturation.
- show_resetn==0 in S_COOK (steak flipped away or burnt out): next state S_IDLE. stage_clk=0, stage_cnt=0, and the in-progress period is discarded.
- Simultaneous events in S_COOK: if show_resetn falls on the same cycle as a toggle tick, the return to S_IDLE wins and no toggle occurs.
- show_time is sampled only in S_IDLE. Changes at any other time are ignored.
- Stage sequence: the first toggle (0→1) advances raw→rare, and each subsequent toggle advances one stage. The 7th toggle ends burnt.

Test Plan:
(All scenarios use TICK_DIV=4, COOK_UNITS=2, SHOW_BASE=1.)
1. Reset 2 cycles, then release with show_resetn=0 and show_time=2 → 1 cycle in S_IDLE, 12 cycles in S_DELAY; show=1 on the 14th cycle after release and held while show_resetn=0.
2. After scenario 1, raise show_resetn=1 with cook_en=1 → show=0 next cycle; stage_clk toggles every 8 cycles (0→1→0…); stage_cnt goes 1..7 and stays 7 thereafter.
3. Mid-cook, drop cook_en for 5 cycles, 3 cycles into a period → that toggle occurs 13 cycles after the period start instead of 8; stage_cnt sequence unchanged.
4. In S_COOK with stage_clk=1 and stage_cnt=3, drop show_resetn and set show_time=0 → next cycle stage_clk=0 and stage_cnt=0; show rises after 1+4 cycles.
5. Set show_time=7 → delay of 8 units = 32 cycles; no width overflow.
6. Assert reset for 1 cycle at cycle 6 of S_DELAY → show, stage_clk and stage_cnt all 0 next cycle; the delay restarts from zero once reset is deasserted.

Source files
------------

// File: rtl/steak_timer.sv
// Spawn-delay and doneness-stage timing source for the steak controller.
// A shared prescaler generates unit ticks; one FSM sequences idle, spawn delay, spawn request and cooking.
module steak_timer #(
  parameter int TICK_DIV   = 50000000,
  parameter int COOK_UNITS = 2,
  parameter int SHOW_BASE  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       show_resetn,
  input  logic [2:0] show_time,
  input  logic       cook_en,
  output logic       show,
  output logic       stage_clk,
  output logic [2:0] stage_cnt
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int UW = ($clog2(COOK_UNITS + 1) > 4) ? $clog2(COOK_UNITS + 1) : 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_SHOW,
    S_COOK
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [UW-1:0] unit_cnt;
  logic [3:0]    delay_units;
  logic          tick;
  logic [UW-1:0] unit_next;

  assign tick      = (presc == PW'(TICK_DIV - 1));
  assign unit_next = unit_cnt + UW'(1);

  // Spawn handshake: show is a request held high until the controller answers
  // with show_resetn=1; show_resetn=0 later means the steak is gone and the cycle restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      show        <= 1'b0;
      stage_clk   <= 1'b0;
      stage_cnt   <= 3'd0;
      presc       <= '0;
      unit_cnt    <= '0;
      delay_units <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          show      <= 1'b0;
          stage_clk <= 1'b0;
          if (!show_resetn) begin
            delay_units <= {1'b0, show_time} + 4'(SHOW_BASE);
            presc       <= '0;
            unit_cnt    <= '0;
            state       <= S_DELAY;
          end
        end

        S_DELAY: begin
          if (show_resetn) begin
            state     <= S_COOK;
            show      <= 1'b0;
            stage_clk <= 1'b0;
            stage_cnt <= 3'd0;
            presc     <= '0;
            unit_cnt  <= '0;
          end else if (delay_units == 4'd0) begin
            state    <= S_SHOW;
            show     <= 1'b1;
            presc    <= '0;
            unit_cnt <= '0;
          end else if (tick) begin
            presc <= '0;
            if (unit_next == UW'(delay_units)) begin
              state    <= S_SHOW;
              show     <= 1'b1;
              unit_cnt <= '0;
            end else begin
              unit_cnt <= unit_next;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end

        S_SHOW: begin
          show <= 1'b1;
          if (show_resetn) begin
            state     <= S_COOK;
            show      <= 1'b0;
            stage_clk <= 1'b0;
            stage_cnt <= 3'd0;
            presc     <= '0;
            unit_cnt  <= '0;
          end
        end

        S_COOK: begin
          // Losing the steak outranks a coincident stage toggle.
          if (!show_resetn) begin
            state     <= S_IDLE;
            show      <= 1'b0;
            stage_clk <= 1'b0;
            stage_cnt <= 3'd0;
            presc     <= '0;
            unit_cnt  <= '0;
          end else if (cook_en) begin
            if (tick) begin
              presc <= '0;
              if (unit_next == UW'(COOK_UNITS)) begin
                unit_cnt  <= '0;
                stage_clk <= ~stage_clk;
                stage_cnt <= (stage_cnt == 3'd7) ? 3'd7 : stage_cnt + 3'd1;
              end else begin
                unit_cnt <= unit_next;
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_steak_timer.sv
// Bench for steak_timer: hand-derived vector table, corner-case sequences and a
// randomized run, all checked every cycle against a cycle-count reference model.
module tb_steak_timer;

  localparam int TICK_DIV   = 4;
  localparam int COOK_UNITS = 2;
  localparam int SHOW_BASE  = 1;
  localparam int PERIOD     = TICK_DIV * COOK_UNITS;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_SHOW = 2;
  localparam int M_COOK = 3;

  // clock / reset
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       show_resetn = 1'b0;
  logic [2:0] show_time = 3'd0;
  logic       cook_en = 1'b0;
  logic       show;
  logic       stage_clk;
  logic [2:0] stage_cnt;

  always #5 clk = ~clk;

  steak_timer #(
    .TICK_DIV  (TICK_DIV),
    .COOK_UNITS(COOK_UNITS),
    .SHOW_BASE (SHOW_BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .show_resetn(show_resetn),
    .show_time  (show_time),
    .cook_en    (cook_en),
    .show       (show),
    .stage_clk  (stage_clk),
    .stage_cnt  (stage_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode plus remaining delay cycles and cook_en-high cycles since cook start.
  int m_mode = M_IDLE;
  int m_remaining = 0;
  int m_active = 0;

  logic [4:0] exp_q[$];

  function automatic logic [4:0] model_outputs();
    int   toggles;
    logic e_show;
    logic e_clk;
    logic [2:0] e_cnt;
    toggles = m_active / PERIOD;
    e_show  = (m_mode == M_SHOW);
    e_clk   = (m_mode == M_COOK) && (toggles % 2 == 1);
    e_cnt   = (m_mode == M_COOK) ? 3'((toggles > 7) ? 7 : toggles) : 3'd0;
    return {e_show, e_clk, e_cnt};
  endfunction

  task automatic model_update(input logic r, input logic srn, input logic [2:0] st, input logic ce);
    if (r) begin
      m_mode   = M_IDLE;
      m_active = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (!srn) begin
          m_mode      = M_WAIT;
          m_remaining = (int'(st) + SHOW_BASE) * TICK_DIV;
        end
        M_WAIT: begin
          if (srn) begin
            m_mode   = M_COOK;
            m_active = 0;
          end else if (m_remaining <= 1) begin
            m_mode = M_SHOW;
          end else begin
            m_remaining--;
          end
        end
        M_SHOW: if (srn) begin
          m_mode   = M_COOK;
          m_active = 0;
        end
        default: begin
          if (!srn) m_mode = M_IDLE;
          else if (ce) m_active++;
        end
      endcase
    end
  endtask

  // driver: one clock with the given inputs, model advanced and compared via the queue
  task automatic step(input logic r, input logic srn, input logic [2:0] st, input logic ce);
    logic [4:0] got;
    logic [4:0] exp;
    reset       = r;
    show_resetn = srn;
    show_time   = st;
    cook_en     = ce;
    @(posedge clk);
    model_update(r, srn, st, ce);
    exp_q.push_back(model_outputs());
    #1;
    got = {show, stage_clk, stage_cnt};
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL model @%0t: got show=%0b stage_clk=%0b stage_cnt=%0d, want show=%0b stage_clk=%0b stage_cnt=%0d",
               $time, got[4], got[3], got[2:0], exp[4], exp[3], exp[2:0]);
    end
  endtask

  task automatic check(input string name, input logic e_show, input logic e_clk, input logic [2:0] e_cnt);
    vectors++;
    if ({show, stage_clk, stage_cnt} !== {e_show, e_clk, e_cnt}) begin
      miscompares++;
      $display("FAIL %s: got show=%0b stage_clk=%0b stage_cnt=%0d, want show=%0b stage_clk=%0b stage_cnt=%0d",
               name, show, stage_clk, stage_cnt, e_show, e_clk, e_cnt);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       srn;
    logic [2:0] st;
    logic       ce;
    int         n;
    logic       e_show;
    logic       e_clk;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic srn_r;

    // spawn with show_time=2, then cook through saturation with one pause
    tbl[0]  = '{1'b1, 1'b0, 3'd0, 1'b0,  2, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{1'b0, 1'b0, 3'd2, 1'b0, 12, 1'b0, 1'b0, 3'd0};
    tbl[2]  = '{1'b0, 1'b0, 3'd2, 1'b0,  1, 1'b1, 1'b0, 3'd0};
    tbl[3]  = '{1'b0, 1'b0, 3'd5, 1'b0,  3, 1'b1, 1'b0, 3'd0};
    tbl[4]  = '{1'b0, 1'b1, 3'd0, 1'b1,  1, 1'b0, 1'b0, 3'd0};
    tbl[5]  = '{1'b0, 1'b1, 3'd0, 1'b1,  7, 1'b0, 1'b0, 3'd0};
    tbl[6]  = '{1'b0, 1'b1, 3'd0, 1'b1,  1, 1'b0, 1'b1, 3'd1};
    tbl[7]  = '{1'b0, 1'b1, 3'd0, 1'b1,  8, 1'b0, 1'b0, 3'd2};
    tbl[8]  = '{1'b0, 1'b1, 3'd0, 1'b1,  8, 1'b0, 1'b1, 3'd3};
    tbl[9]  = '{1'b0, 1'b1, 3'd0, 1'b1,  3, 1'b0, 1'b1, 3'd3};
    tbl[10] = '{1'b0, 1'b1, 3'd0, 1'b0,  5, 1'b0, 1'b1, 3'd3};
    tbl[11] = '{1'b0, 1'b1, 3'd0, 1'b1,  4, 1'b0, 1'b1, 3'd3};
    tbl[12] = '{1'b0, 1'b1, 3'd0, 1'b1,  1, 1'b0, 1'b0, 3'd4};
    tbl[13] = '{1'b0, 1'b1, 3'd0, 1'b1, 24, 1'b0, 1'b1, 3'd7};
    tbl[14] = '{1'b0, 1'b1, 3'd0, 1'b1,  8, 1'b0, 1'b0, 3'd7};
    tbl[15] = '{1'b0, 1'b1, 3'd0, 1'b1,  8, 1'b0, 1'b1, 3'd7};

    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].rst, tbl[i].srn, tbl[i].st, tbl[i].ce);
      check($sformatf("tbl[%0d]", i), tbl[i].e_show, tbl[i].e_clk, tbl[i].e_cnt);
    end

    // leave cook at stage_clk=1/stage_cnt=3, respawn with show_time=0
    step(1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 3'd0, 1'b0);
    check("short_spawn", 1'b1, 1'b0, 3'd0);
    step(1'b0, 1'b1, 3'd0, 1'b1);
    repeat (24) step(1'b0, 1'b1, 3'd0, 1'b1);
    check("cook_stage3", 1'b0, 1'b1, 3'd3);
    step(1'b0, 1'b0, 3'd0, 1'b1);
    check("flip_away", 1'b0, 1'b0, 3'd0);
    repeat (4) step(1'b0, 1'b0, 3'd0, 1'b0);
    check("respawn_wait", 1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 3'd0, 1'b0);
    check("respawn_show", 1'b1, 1'b0, 3'd0);

    // steak lost on the very cycle a toggle is due
    step(1'b0, 1'b1, 3'd0, 1'b1);
    repeat (7) step(1'b0, 1'b1, 3'd0, 1'b1);
    check("pre_toggle", 1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 3'd0, 1'b1);
    check("drop_beats_toggle", 1'b0, 1'b0, 3'd0);

    // longest delay: 8 units, show_time changes mid-delay ignored
    step(1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 3'd7, 1'b0);
    repeat (31) step(1'b0, 1'b0, 3'd0, 1'b0);
    check("max_delay_wait", 1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 3'd0, 1'b0);
    check("max_delay_show", 1'b1, 1'b0, 3'd0);

    // steak appears mid-delay: straight to cook
    step(1'b1, 1'b0, 3'd0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 3'd3, 1'b0);
    step(1'b0, 1'b1, 3'd0, 1'b1);
    check("delay_to_cook", 1'b0, 1'b0, 3'd0);
    repeat (8) step(1'b0, 1'b1, 3'd0, 1'b1);
    check("delay_cook_toggle", 1'b0, 1'b1, 3'd1);

    // reset in delay cycle 6 restarts the delay
    step(1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 3'd2, 1'b0);
    repeat (5) step(1'b0, 1'b0, 3'd2, 1'b0);
    step(1'b1, 1'b0, 3'd2, 1'b0);
    check("mid_delay_reset", 1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 3'd2, 1'b0);
    repeat (11) step(1'b0, 1'b0, 3'd2, 1'b0);
    check("restart_wait", 1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 3'd2, 1'b0);
    check("restart_show", 1'b1, 1'b0, 3'd0);

    // randomized run against the model
    srn_r = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) srn_r = ~srn_r;
      step(($urandom_range(0, 199) == 0), srn_r, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
